// File: rtl/cursor_pkg.sv
// Shared constants, state encoding and the proximity helper for the cursor tracking path.
package cursor_pkg;

  localparam int POS_W = 13;

  localparam logic [12:0] X_MAX     = 13'd799;
  localparam logic [12:0] Y_MAX     = 13'd599;
  localparam logic [12:0] X_MAX_fin = 13'd800;
  localparam logic [12:0] Y_MAX_fin = 13'd600;
  localparam logic [12:0] TOL       = 13'd8;

  localparam logic [3:0] STABLE_FRAMES = 4'd3;
  localparam logic [3:0] LOST_FRAMES   = 4'd8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SEARCH = 2'd1;
  localparam state_t ST_LOCKED = 2'd2;
  localparam state_t ST_COAST  = 2'd3;

  // Compare before subtracting so the unsigned distance never wraps.
  function automatic logic pos_near(input logic [12:0] ax, input logic [12:0] ay,
                                    input logic [12:0] bx, input logic [12:0] by);
    logic [12:0] dx;
    logic [12:0] dy;
    dx = (ax >= bx) ? (ax - bx) : (bx - ax);
    dy = (ay >= by) ? (ay - by) : (by - ay);
    return (dx <= TOL) && (dy <= TOL);
  endfunction

endpackage

// File: rtl/cursor_hit_capture.sv
// Registers the scan position and colour flag, latches the first hit of each frame and
// flags the frame-end evaluation cycle.
module cursor_hit_capture
  import cursor_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [12:0] i_X_pos,
  input  logic [12:0] i_Y_pos,
  input  logic        check_color,
  output logic        o_eval,
  output logic        o_hit,
  output logic [12:0] o_hx,
  output logic [12:0] o_hy
);

  logic        hit_q;
  logic [12:0] col_q;
  logic [12:0] row_q;
  logic        found_q, found_d;
  logic [12:0] hx_q, hx_d;
  logic [12:0] hy_q, hy_d;
  logic        end_s;

  // Input pipeline and first-hit latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q   <= 1'b0;
      col_q   <= 13'd0;
      row_q   <= 13'd0;
      found_q <= 1'b0;
      hx_q    <= 13'd0;
      hy_q    <= 13'd0;
    end else begin
      hit_q   <= check_color;
      col_q   <= i_X_pos;
      row_q   <= i_Y_pos;
      found_q <= found_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
    end
  end

  assign end_s = (col_q == X_MAX) && (row_q == Y_MAX);

  // Disable discards the frame; frame end re-arms the latch for the next frame.
  always_comb begin
    found_d = found_q;
    hx_d    = hx_q;
    hy_d    = hy_q;
    if (!i_enable || end_s) begin
      found_d = 1'b0;
    end else if (hit_q && !found_q) begin
      found_d = 1'b1;
      hx_d    = col_q;
      hy_d    = row_q;
    end else begin
      found_d = found_q;
    end
  end

  // A hit on the final pixel itself still counts for this frame.
  assign o_eval = end_s && i_enable;
  assign o_hit  = found_q || hit_q;
  assign o_hx   = found_q ? hx_q : col_q;
  assign o_hy   = found_q ? hy_q : row_q;

endmodule

// File: rtl/cursor_track_ctrl.sv
// Per-frame cursor lock sequencer: confirms a stable hit, coasts through dropouts and
// hands one position per frame to the drawing engine over valid/ready.
module cursor_track_ctrl
  import cursor_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [12:0] i_X_pos,
  input  logic [12:0] i_Y_pos,
  input  logic        check_color,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [12:0] o_X,
  output logic [12:0] o_Y,
  output logic        o_locked,
  output logic        o_coast,
  output logic        o_drop,
  output logic [1:0]  o_state
);

  logic        eval_s, hit_s, near_s;
  logic [12:0] hx_s, hy_s;
  state_t      state_q, state_d;
  logic [3:0]  stab_q, stab_d, miss_q, miss_d, stab_inc_s, miss_inc_s;
  logic [12:0] px_q, px_d, py_q, py_d;
  logic        emit_s, emit_coast_s;
  logic [12:0] emit_x_s, emit_y_s;
  logic        valid_q, valid_d, coast_q, coast_d, drop_q, drop_d;
  logic [12:0] x_q, x_d, y_q, y_d;

  cursor_hit_capture u_capture (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (i_enable),
    .i_X_pos    (i_X_pos),
    .i_Y_pos    (i_Y_pos),
    .check_color(check_color),
    .o_eval     (eval_s),
    .o_hit      (hit_s),
    .o_hx       (hx_s),
    .o_hy       (hy_s)
  );

  assign near_s     = pos_near(hx_s, hy_s, px_q, py_q);
  assign stab_inc_s = (stab_q >= STABLE_FRAMES) ? STABLE_FRAMES : (stab_q + 4'd1);
  assign miss_inc_s = (miss_q >= LOST_FRAMES) ? LOST_FRAMES : (miss_q + 4'd1);

  // Lock sequencing; only the frame-end cycle moves the FSM while enabled.
  always_comb begin
    state_d      = state_q;
    stab_d       = stab_q;
    miss_d       = miss_q;
    px_d         = px_q;
    py_d         = py_q;
    emit_s       = 1'b0;
    emit_coast_s = 1'b0;
    emit_x_s     = px_q;
    emit_y_s     = py_q;
    if (!i_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SEARCH;
          stab_d  = 4'd0;
          miss_d  = 4'd0;
        end
        ST_SEARCH: begin
          if (eval_s && hit_s) begin
            px_d = hx_s;
            py_d = hy_s;
            if ((stab_q == 4'd0) || near_s) begin
              stab_d = stab_inc_s;
              if (stab_inc_s >= STABLE_FRAMES) begin
                state_d  = ST_LOCKED;
                miss_d   = 4'd0;
                emit_s   = 1'b1;
                emit_x_s = hx_s;
                emit_y_s = hy_s;
              end else begin
                state_d = ST_SEARCH;
              end
            end else begin
              stab_d = 4'd1;
            end
          end else if (eval_s) begin
            stab_d = 4'd0;
          end else begin
            stab_d = stab_q;
          end
        end
        ST_LOCKED: begin
          if (eval_s && hit_s) begin
            px_d     = hx_s;
            py_d     = hy_s;
            emit_s   = 1'b1;
            emit_x_s = hx_s;
            emit_y_s = hy_s;
          end else if (eval_s) begin
            state_d      = ST_COAST;
            miss_d       = 4'd1;
            emit_s       = 1'b1;
            emit_coast_s = 1'b1;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        ST_COAST: begin
          if (eval_s && hit_s) begin
            px_d = hx_s;
            py_d = hy_s;
            if (near_s) begin
              state_d  = ST_LOCKED;
              miss_d   = 4'd0;
              emit_s   = 1'b1;
              emit_x_s = hx_s;
              emit_y_s = hy_s;
            end else begin
              state_d = ST_SEARCH;
              stab_d  = 4'd1;
            end
          end else if (eval_s) begin
            miss_d = miss_inc_s;
            if (miss_inc_s >= LOST_FRAMES) begin
              state_d = ST_SEARCH;
              stab_d  = 4'd0;
            end else begin
              emit_s       = 1'b1;
              emit_coast_s = 1'b1;
            end
          end else begin
            state_d = ST_COAST;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Result register: a fresh emit always wins; losing an unaccepted result flags o_drop.
  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    coast_d = coast_q;
    drop_d  = 1'b0;
    if (emit_s) begin
      valid_d = 1'b1;
      x_d     = emit_x_s;
      y_d     = emit_y_s;
      coast_d = emit_coast_s;
      drop_d  = valid_q && !i_ready;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      stab_q  <= 4'd0;
      miss_q  <= 4'd0;
      px_q    <= 13'd0;
      py_q    <= 13'd0;
      valid_q <= 1'b0;
      x_q     <= X_MAX_fin;
      y_q     <= Y_MAX_fin;
      coast_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      miss_q  <= miss_d;
      px_q    <= px_d;
      py_q    <= py_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      coast_q <= coast_d;
      drop_q  <= drop_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_X      = x_q;
  assign o_Y      = y_q;
  assign o_coast  = coast_q;
  assign o_drop   = drop_q;
  assign o_state  = state_q;
  assign o_locked = (state_q == ST_LOCKED) || (state_q == ST_COAST);

endmodule

// File: tb/tb_cursor_track_ctrl.sv
// Directed bench for cursor_track_ctrl using compressed frames: only blob pixels and the
// final (799,599) pixel are scanned, which is all the tracker observes.
module tb_cursor_track_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_enable = 1'b0;
  logic [12:0] i_X_pos = 13'd0;
  logic [12:0] i_Y_pos = 13'd0;
  logic        check_color = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_valid, o_locked, o_coast, o_drop;
  logic [12:0] o_X, o_Y;
  logic [1:0]  o_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cursor_track_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (i_enable),
    .i_X_pos    (i_X_pos),
    .i_Y_pos    (i_Y_pos),
    .check_color(check_color),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_X        (o_X),
    .o_Y        (o_Y),
    .o_locked   (o_locked),
    .o_coast    (o_coast),
    .o_drop     (o_drop),
    .o_state    (o_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input int x, input int y, input logic c);
    i_X_pos     = 13'(x);
    i_Y_pos     = 13'(y);
    check_color = c;
    tick();
  endtask

  // Blob (optional 3x3 at bx,by), frame-end pixel, then one idle pixel so results are visible.
  task automatic frame(input logic blob, input int bx, input int by);
    px(0, 0, 1'b0);
    if (blob) begin
      for (int dy = 0; dy < 3; dy++)
        for (int dx = 0; dx < 3; dx++)
          px(bx + dx, by + dy, 1'b1);
    end
    px(799, 599, 1'b0);
    px(0, 0, 1'b0);
  endtask

  task automatic check_emit(input string tag, input int st, input int x, input int y, input logic cst);
    check_eq({tag, "_state"}, 32'(o_state), 32'(st));
    check_eq({tag, "_valid"}, 32'(o_valid), 32'd1);
    check_eq({tag, "_x"}, 32'(o_X), 32'(x));
    check_eq({tag, "_y"}, 32'(o_Y), 32'(y));
    check_eq({tag, "_coast"}, 32'(o_coast), 32'(cst));
  endtask

  initial begin
    #2 rst = 1'b0;
    #3;
    check_eq("rst_state", 32'(o_state), 32'd0);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_x", 32'(o_X), 32'd800);
    check_eq("rst_y", 32'(o_Y), 32'd600);
    check_eq("rst_locked", 32'(o_locked), 32'd0);
    check_eq("rst_coast", 32'(o_coast), 32'd0);
    check_eq("rst_drop", 32'(o_drop), 32'd0);
    tick();
    rst = 1'b1;
    i_ready = 1'b1;
    i_enable = 1'b1;
    tick();
    check_eq("en_search", 32'(o_state), 32'd1);

    // Acquire: two frames in SEARCH, lock at the third.
    frame(1'b1, 100, 200);
    check_eq("acq_f1_state", 32'(o_state), 32'd1);
    frame(1'b1, 100, 200);
    check_eq("acq_f2_state", 32'(o_state), 32'd1);
    check_eq("acq_f2_valid", 32'(o_valid), 32'd0);
    frame(1'b1, 100, 200);
    check_emit("acq_f3", 2, 100, 200, 1'b0);
    check_eq("acq_locked", 32'(o_locked), 32'd1);

    // LOCKED follows both near and far hits.
    frame(1'b1, 105, 196);
    check_emit("trk_near", 2, 105, 196, 1'b0);
    frame(1'b1, 300, 300);
    check_emit("trk_far", 2, 300, 300, 1'b0);

    // Short dropout then recovery.
    frame(1'b0, 0, 0);
    check_emit("coast1", 3, 300, 300, 1'b1);
    check_eq("coast1_locked", 32'(o_locked), 32'd1);
    frame(1'b0, 0, 0);
    check_emit("coast2", 3, 300, 300, 1'b1);
    frame(1'b1, 302, 301);
    check_emit("relock", 2, 302, 301, 1'b0);

    // Long dropout: seven coast emits, the eighth miss drops the lock silently.
    for (int f = 0; f < 7; f++) frame(1'b0, 0, 0);
    check_emit("lost_f7", 3, 302, 301, 1'b1);
    frame(1'b0, 0, 0);
    check_eq("lost_f8_state", 32'(o_state), 32'd1);
    check_eq("lost_f8_locked", 32'(o_locked), 32'd0);
    check_eq("lost_f8_valid", 32'(o_valid), 32'd0);

    // Reacquire elsewhere.
    for (int f = 0; f < 3; f++) frame(1'b1, 400, 100);
    check_emit("reacq", 2, 400, 100, 1'b0);
    tick();
    check_eq("reacq_accept", 32'(o_valid), 32'd0);

    // Back-pressure: second emit overwrites the unaccepted first one.
    i_ready = 1'b0;
    frame(1'b1, 410, 105);
    check_emit("bp_1", 2, 410, 105, 1'b0);
    check_eq("bp_1_drop", 32'(o_drop), 32'd0);
    frame(1'b1, 500, 500);
    check_emit("bp_2", 2, 500, 500, 1'b0);
    check_eq("bp_2_drop", 32'(o_drop), 32'd1);
    tick();
    check_eq("bp_drop_pulse", 32'(o_drop), 32'd0);
    check_eq("bp_hold_x", 32'(o_X), 32'd500);
    check_eq("bp_hold_valid", 32'(o_valid), 32'd1);
    i_ready = 1'b1;
    tick();
    check_eq("bp_accept", 32'(o_valid), 32'd0);

    // Hit only on the final pixel is still this frame's hit.
    px(0, 0, 1'b0);
    px(799, 599, 1'b1);
    px(0, 0, 1'b0);
    check_emit("endpix", 2, 799, 599, 1'b0);

    // Disable mid-frame: IDLE next cycle, pending result stays.
    i_ready = 1'b0;
    px(100, 100, 1'b1);
    i_enable = 1'b0;
    px(101, 100, 1'b1);
    check_eq("dis_state", 32'(o_state), 32'd0);
    check_eq("dis_valid", 32'(o_valid), 32'd1);
    check_eq("dis_x", 32'(o_X), 32'd799);
    check_eq("dis_locked", 32'(o_locked), 32'd0);
    px(799, 599, 1'b1);
    px(0, 0, 1'b0);
    check_eq("dis_noeval_state", 32'(o_state), 32'd0);
    check_eq("dis_noeval_y", 32'(o_Y), 32'd599);
    i_enable = 1'b1;
    tick();
    check_eq("reen_state", 32'(o_state), 32'd1);
    check_eq("reen_valid", 32'(o_valid), 32'd1);

    // Asynchronous reset mid-frame clears outputs without a clock edge.
    px(5, 5, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_state", 32'(o_state), 32'd0);
    check_eq("arst_valid", 32'(o_valid), 32'd0);
    check_eq("arst_x", 32'(o_X), 32'd800);
    check_eq("arst_y", 32'(o_Y), 32'd600);
    check_eq("arst_locked", 32'(o_locked), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
